// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing and tag types for the rename-stage physical register free list.
// PREG_W must stay in step with the rd/rd_old/rs1/rs2 fields of dispatchStruct.
package phys_reg_free_list_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int FL_PTR_W  = $clog2(FL_DEPTH);
    localparam int FL_CNT_W  = $clog2(FL_DEPTH + 1);

    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;

    // Architectural regs own p0..p(NUM_AREGS-1) after reset; the rest start free.
    function automatic preg_t init_tag(input fl_ptr_t idx);
        return preg_t'(NUM_AREGS) + preg_t'(idx);
    endfunction

endpackage

// File: rtl/phys_reg_free_list_fl_ram_2r2w.sv
// Free-list storage: FL_DEPTH tag entries, two combinational reads at ptr/ptr+1
// and two synchronous writes at ptr/ptr+1 with write b compacted onto ptr when write a is idle.
module fl_ram_2r2w
    import phys_reg_free_list_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_reset,
    input  fl_ptr_t i_rd_ptr,
    output preg_t   o_rd_a,
    output preg_t   o_rd_b,
    input  fl_ptr_t i_wr_ptr,
    input  logic    i_we_a,
    input  preg_t   i_wd_a,
    input  logic    i_we_b,
    input  preg_t   i_wd_b
);

    preg_t   r_mem [FL_DEPTH];
    fl_ptr_t w_rd_ptr_b;
    fl_ptr_t w_wr_ptr_b;

    assign w_rd_ptr_b = i_rd_ptr + fl_ptr_t'(1);
    assign w_wr_ptr_b = i_we_a ? (i_wr_ptr + fl_ptr_t'(1)) : i_wr_ptr;

    assign o_rd_a = r_mem[i_rd_ptr];
    assign o_rd_b = r_mem[w_rd_ptr_b];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_mem[i] <= init_tag(fl_ptr_t'(i));
            end
        end else begin
            if (i_we_a) begin
                r_mem[i_wr_ptr] <= i_wd_a;
            end
            if (i_we_b) begin
                r_mem[w_wr_ptr_b] <= i_wd_b;
            end
        end
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list for the 2-wide rename stage: pops tags at head for
// decode lanes a/b, pushes ROB-retired rd_old tags at tail, and tracks the free count.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    alloc_req_a,
    input  logic    alloc_req_b,
    output logic    alloc_ok,
    output preg_t   alloc_tag_a,
    output preg_t   alloc_tag_b,
    input  logic    rel_valid_a,
    input  preg_t   rel_tag_a,
    input  logic    rel_valid_b,
    input  preg_t   rel_tag_b,
    output fl_cnt_t free_count,
    output logic    fl_err
);

    localparam logic [FL_CNT_W:0] FL_DEPTH_X = FL_DEPTH[FL_CNT_W:0];

    fl_ptr_t r_head;
    fl_ptr_t r_tail;
    fl_cnt_t r_free_count;
    logic    r_fl_err;

    logic [1:0]        w_n_req;
    logic [1:0]        w_n_alloc;
    logic              w_alloc_ok;
    logic              w_rel_ok_a;
    logic              w_rel_ok_b;
    logic              w_zero_err;
    logic [1:0]        w_n_rel_cand;
    logic              w_ovf;
    logic              w_acc_a;
    logic              w_acc_b;
    logic [1:0]        w_n_acc;
    logic [FL_CNT_W:0] w_avail;
    logic [FL_CNT_W:0] w_cnt_if_all;
    logic [FL_CNT_W:0] w_cnt_next;
    preg_t             w_rd_a;
    preg_t             w_rd_b;

    // Handshake: alloc_req_x is a request, alloc_ok is the grant for every request
    // asserted this cycle (all-or-nothing); a lane consumes its tag only when req && alloc_ok,
    // and the grant commits at the next rising edge. No ready/backpressure exists on release.
    assign w_n_req    = {1'b0, alloc_req_a} + {1'b0, alloc_req_b};
    assign w_alloc_ok = (fl_cnt_t'(w_n_req) <= r_free_count);
    assign w_n_alloc  = w_alloc_ok ? w_n_req : 2'd0;

    assign w_rel_ok_a   = rel_valid_a && (rel_tag_a != '0);
    assign w_rel_ok_b   = rel_valid_b && (rel_tag_b != '0);
    assign w_zero_err   = (rel_valid_a && (rel_tag_a == '0)) || (rel_valid_b && (rel_tag_b == '0));
    assign w_n_rel_cand = {1'b0, w_rel_ok_a} + {1'b0, w_rel_ok_b};

    always_comb begin
        w_avail      = '0;
        w_avail      = {1'b0, r_free_count} - {{(FL_CNT_W-1){1'b0}}, w_n_alloc};
        w_cnt_if_all = w_avail + {{(FL_CNT_W-1){1'b0}}, w_n_rel_cand};
    end

    // More free tags than entries means a double free upstream; drop the whole cycle's releases.
    assign w_ovf   = (w_cnt_if_all > FL_DEPTH_X);
    assign w_acc_a = w_rel_ok_a && !w_ovf;
    assign w_acc_b = w_rel_ok_b && !w_ovf;
    assign w_n_acc = {1'b0, w_acc_a} + {1'b0, w_acc_b};

    assign w_cnt_next = w_avail + {{(FL_CNT_W-1){1'b0}}, w_n_acc};

    fl_ram_2r2w u_fl_ram (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_rd_ptr (r_head),
        .o_rd_a   (w_rd_a),
        .o_rd_b   (w_rd_b),
        .i_wr_ptr (r_tail),
        .i_we_a   (w_acc_a),
        .i_wd_a   (rel_tag_a),
        .i_we_b   (w_acc_b),
        .i_wd_b   (rel_tag_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_free_count <= fl_cnt_t'(FL_DEPTH);
            r_fl_err     <= 1'b0;
        end else begin
            r_head       <= r_head + fl_ptr_t'(w_n_alloc);
            r_tail       <= r_tail + fl_ptr_t'(w_n_acc);
            r_free_count <= w_cnt_next[FL_CNT_W-1:0];
            r_fl_err     <= r_fl_err | w_zero_err | w_ovf;
        end
    end

    assign alloc_ok    = w_alloc_ok;
    assign alloc_tag_a = w_rd_a;
    assign alloc_tag_b = alloc_req_a ? w_rd_b : w_rd_a;
    assign free_count  = r_free_count;
    assign fl_err      = r_fl_err;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus a randomized alloc/release
// run, all checked against a queue model of the free tags.
module tb_phys_reg_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req_a, alloc_req_b;
    logic       alloc_ok;
    logic [5:0] alloc_tag_a, alloc_tag_b;
    logic       rel_valid_a, rel_valid_b;
    logic [5:0] rel_tag_a, rel_tag_b;
    logic [5:0] free_count;
    logic       fl_err;

    int n_cmp = 0;
    int n_err = 0;

    // Model: free tags in allocation order, plus sticky error flag.
    logic [5:0] exp_q[$];
    logic       exp_err;

    always #5 clk = ~clk;

    phys_reg_free_list dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_req_a (alloc_req_a),
        .alloc_req_b (alloc_req_b),
        .alloc_ok    (alloc_ok),
        .alloc_tag_a (alloc_tag_a),
        .alloc_tag_b (alloc_tag_b),
        .rel_valid_a (rel_valid_a),
        .rel_tag_a   (rel_tag_a),
        .rel_valid_b (rel_valid_b),
        .rel_tag_b   (rel_tag_b),
        .free_count  (free_count),
        .fl_err      (fl_err)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ra, input logic rb, input logic va, input logic [5:0] ta,
                         input logic vb, input logic [5:0] tbg);
        alloc_req_a = ra;
        alloc_req_b = rb;
        rel_valid_a = va;
        rel_tag_a   = ta;
        rel_valid_b = vb;
        rel_tag_b   = tbg;
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
        exp_err = 1'b0;
    endtask

    // Advance one clock with the currently driven inputs and apply the free-list rules to the model.
    task automatic step_commit();
        int         n_req;
        logic [5:0] cand[$];
        n_req = int'(alloc_req_a) + int'(alloc_req_b);
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (n_req <= exp_q.size()) begin
                repeat (n_req) void'(exp_q.pop_front());
            end
            if (rel_valid_a) begin
                if (rel_tag_a == 6'd0) exp_err = 1'b1;
                else cand.push_back(rel_tag_a);
            end
            if (rel_valid_b) begin
                if (rel_tag_b == 6'd0) exp_err = 1'b1;
                else cand.push_back(rel_tag_b);
            end
            if (exp_q.size() + cand.size() > 32) begin
                exp_err = 1'b1;
            end else begin
                foreach (cand[j]) exp_q.push_back(cand[j]);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        step_commit();
        step_commit();
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL reset_free_count: got %0d want 32", free_count); end
        n_cmp++; if (alloc_ok !== 1'b1) begin n_err++; $display("FAIL reset_alloc_ok: got %0b want 1", alloc_ok); end
        n_cmp++; if (alloc_tag_a !== 6'd32) begin n_err++; $display("FAIL reset_tag_a: got %0d want 32", alloc_tag_a); end
        n_cmp++; if (alloc_tag_b !== 6'd32) begin n_err++; $display("FAIL reset_tag_b: got %0d want 32", alloc_tag_b); end
        n_cmp++; if (fl_err !== 1'b0) begin n_err++; $display("FAIL reset_fl_err: got %0b want 0", fl_err); end
        step_commit();
        n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL idle_free_count: got %0d want 32", free_count); end
    endtask

    task automatic test_drain();
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
            n_cmp++; if (alloc_ok !== 1'b1) begin n_err++; $display("FAIL drain_ok[%0d]: got %0b want 1", k, alloc_ok); end
            n_cmp++; if (alloc_tag_a !== 6'(32 + 2*k)) begin n_err++; $display("FAIL drain_tag_a[%0d]: got %0d want %0d", k, alloc_tag_a, 32 + 2*k); end
            n_cmp++; if (alloc_tag_b !== 6'(33 + 2*k)) begin n_err++; $display("FAIL drain_tag_b[%0d]: got %0d want %0d", k, alloc_tag_b, 33 + 2*k); end
            step_commit();
        end
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (free_count !== 6'd0) begin n_err++; $display("FAIL drain_empty_count: got %0d want 0", free_count); end
        n_cmp++; if (alloc_ok !== 1'b0) begin n_err++; $display("FAIL drain_empty_stall: got %0b want 0", alloc_ok); end
        step_commit();
        n_cmp++; if (free_count !== 6'd0) begin n_err++; $display("FAIL drain_stall_count: got %0d want 0", free_count); end
    endtask

    task automatic test_lane_b();
        apply_reset();
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (alloc_ok !== 1'b1) begin n_err++; $display("FAIL laneb_ok: got %0b want 1", alloc_ok); end
        n_cmp++; if (alloc_tag_b !== 6'd32) begin n_err++; $display("FAIL laneb_tag_b: got %0d want 32", alloc_tag_b); end
        step_commit();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (alloc_tag_a !== 6'd33) begin n_err++; $display("FAIL laneb_next_tag_a: got %0d want 33", alloc_tag_a); end
        step_commit();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (free_count !== 6'd30) begin n_err++; $display("FAIL laneb_count: got %0d want 30", free_count); end
    endtask

    task automatic test_release_at_empty();
        apply_reset();
        repeat (16) begin
            drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
            step_commit();
        end
        drive(1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 6'd9);
        n_cmp++; if (alloc_ok !== 1'b0) begin n_err++; $display("FAIL relempty_stall: got %0b want 0", alloc_ok); end
        step_commit();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (free_count !== 6'd2) begin n_err++; $display("FAIL relempty_count: got %0d want 2", free_count); end
        n_cmp++; if (alloc_ok !== 1'b1) begin n_err++; $display("FAIL relempty_ok: got %0b want 1", alloc_ok); end
        n_cmp++; if (alloc_tag_a !== 6'd5) begin n_err++; $display("FAIL relempty_tag_a: got %0d want 5", alloc_tag_a); end
        step_commit();
        drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (alloc_tag_a !== 6'd9) begin n_err++; $display("FAIL relempty_head9: got %0d want 9", alloc_tag_a); end
        n_cmp++; if (alloc_ok !== 1'b0) begin n_err++; $display("FAIL count1_req2_stall: got %0b want 0", alloc_ok); end
        step_commit();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (free_count !== 6'd1) begin n_err++; $display("FAIL count1_kept: got %0d want 1", free_count); end
        n_cmp++; if (alloc_tag_a !== 6'd9) begin n_err++; $display("FAIL count1_head_kept: got %0d want 9", alloc_tag_a); end
        n_cmp++; if (fl_err !== 1'b0) begin n_err++; $display("FAIL relempty_fl_err: got %0b want 0", fl_err); end
    endtask

    task automatic test_back_to_back();
        int guard;
        apply_reset();
        drive(1'b1, 1'b1, 1'b1, 6'd7, 1'b1, 6'd8);
        n_cmp++; if (alloc_ok !== 1'b1) begin n_err++; $display("FAIL b2b_ok: got %0b want 1", alloc_ok); end
        step_commit();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL b2b_count: got %0d want 32", free_count); end
        n_cmp++; if (fl_err !== 1'b0) begin n_err++; $display("FAIL b2b_fl_err: got %0b want 0", fl_err); end
        n_cmp++; if (alloc_tag_a !== 6'd34) begin n_err++; $display("FAIL b2b_head: got %0d want 34", alloc_tag_a); end
        guard = 0;
        while (exp_q.size() >= 2 && guard < 20) begin
            drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
            n_cmp++; if (alloc_tag_a !== exp_q[0] || alloc_tag_b !== exp_q[1]) begin
                n_err++; $display("FAIL b2b_wrap_tags: got %0d,%0d want %0d,%0d", alloc_tag_a, alloc_tag_b, exp_q[0], exp_q[1]);
            end
            step_commit();
            guard++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_wrap_bound: %0d tags left want 0", exp_q.size()); end
    endtask

    task automatic test_random_wrap();
        logic [5:0] in_use[$];
        logic       ra, rb, va, vb, exp_ok, dup;
        logic [5:0] ta, tbg, eb;
        int         n_req, avail, n_rel, idx, guard;
        apply_reset();
        for (int t = 1; t < 32; t++) in_use.push_back(6'(t));
        for (int cyc = 0; cyc < 100; cyc++) begin
            ra     = 1'($urandom_range(0, 1));
            rb     = 1'($urandom_range(0, 1));
            n_req  = int'(ra) + int'(rb);
            exp_ok = (n_req <= exp_q.size());
            avail  = exp_q.size() - (exp_ok ? n_req : 0);
            n_rel  = $urandom_range(0, 2);
            if (n_rel > 32 - avail) n_rel = 32 - avail;
            if (n_rel > in_use.size()) n_rel = in_use.size();
            va = 1'b0; vb = 1'b0; ta = 6'd0; tbg = 6'd0;
            if (n_rel >= 1) begin
                idx = $urandom_range(0, in_use.size() - 1);
                ta = in_use[idx]; in_use.delete(idx); va = 1'b1;
            end
            if (n_rel == 2) begin
                idx = $urandom_range(0, in_use.size() - 1);
                tbg = in_use[idx]; in_use.delete(idx); vb = 1'b1;
            end else if (n_rel == 1 && $urandom_range(0, 1) == 1) begin
                tbg = ta; vb = 1'b1; ta = 6'd0; va = 1'b0;
            end
            drive(ra, rb, va, ta, vb, tbg);
            n_cmp++; if (alloc_ok !== exp_ok) begin n_err++; $display("FAIL rand_ok[%0d]: got %0b want %0b", cyc, alloc_ok, exp_ok); end
            n_cmp++; if (free_count !== 6'(exp_q.size())) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", cyc, free_count, exp_q.size()); end
            if (exp_ok && ra) begin
                n_cmp++; if (alloc_tag_a !== exp_q[0]) begin n_err++; $display("FAIL rand_tag_a[%0d]: got %0d want %0d", cyc, alloc_tag_a, exp_q[0]); end
                dup = 1'b0;
                foreach (in_use[j]) if (in_use[j] == alloc_tag_a) dup = 1'b1;
                n_cmp++; if (dup) begin n_err++; $display("FAIL rand_dup_a[%0d]: tag %0d issued while in use, want a free tag", cyc, alloc_tag_a); end
            end
            if (exp_ok && rb) begin
                eb = ra ? exp_q[1] : exp_q[0];
                n_cmp++; if (alloc_tag_b !== eb) begin n_err++; $display("FAIL rand_tag_b[%0d]: got %0d want %0d", cyc, alloc_tag_b, eb); end
                dup = 1'b0;
                foreach (in_use[j]) if (in_use[j] == alloc_tag_b) dup = 1'b1;
                n_cmp++; if (dup) begin n_err++; $display("FAIL rand_dup_b[%0d]: tag %0d issued while in use, want a free tag", cyc, alloc_tag_b); end
            end
            if (exp_ok && ra) in_use.push_back(exp_q[0]);
            if (exp_ok && rb) in_use.push_back(ra ? exp_q[1] : exp_q[0]);
            step_commit();
            n_cmp++; if (fl_err !== 1'b0) begin n_err++; $display("FAIL rand_fl_err[%0d]: got %0b want 0", cyc, fl_err); end
        end
        // Drain what is left and compare every remaining free tag in order.
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
            n_cmp++; if (alloc_tag_a !== exp_q[0]) begin n_err++; $display("FAIL rand_drain_tag: got %0d want %0d", alloc_tag_a, exp_q[0]); end
            step_commit();
            guard++;
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (free_count !== 6'd0) begin n_err++; $display("FAIL rand_drain_count: got %0d want 0", free_count); end
    endtask

    task automatic test_errors();
        apply_reset();
        drive(1'b0, 1'b0, 1'b1, 6'd40, 1'b0, 6'd0);
        step_commit();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (fl_err !== exp_err || fl_err !== 1'b1) begin n_err++; $display("FAIL ovf_fl_err: got %0b want 1", fl_err); end
        n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL ovf_count: got %0d want 32", free_count); end
        repeat (3) step_commit();
        n_cmp++; if (fl_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b want 1", fl_err); end
        n_cmp++; if (alloc_tag_a !== 6'd32) begin n_err++; $display("FAIL ovf_head_kept: got %0d want 32", alloc_tag_a); end
        apply_reset();
        drive(1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (fl_err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %0b want 0", fl_err); end
        step_commit();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (fl_err !== 1'b1) begin n_err++; $display("FAIL zero_rel_err: got %0b want 1", fl_err); end
        n_cmp++; if (free_count !== 6'd31) begin n_err++; $display("FAIL zero_rel_count: got %0d want 31", free_count); end
        n_cmp++; if (alloc_tag_a !== 6'd33) begin n_err++; $display("FAIL zero_rel_head: got %0d want 33", alloc_tag_a); end
        // Mid-stream reset with traffic still asserted.
        repeat (3) begin
            drive(1'b1, 1'b1, 1'b1, 6'd12, 1'b0, 6'd0);
            step_commit();
        end
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 6'd40, 1'b1, 6'd0);
        step_commit();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL midrst_count: got %0d want 32", free_count); end
        n_cmp++; if (alloc_ok !== 1'b1) begin n_err++; $display("FAIL midrst_ok: got %0b want 1", alloc_ok); end
        n_cmp++; if (alloc_tag_a !== 6'd32 || alloc_tag_b !== 6'd32) begin n_err++; $display("FAIL midrst_tags: got %0d,%0d want 32,32", alloc_tag_a, alloc_tag_b); end
        n_cmp++; if (fl_err !== 1'b0) begin n_err++; $display("FAIL midrst_fl_err: got %0b want 0", fl_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        test_reset();
        test_drain();
        test_lane_b();
        test_release_at_empty();
        test_back_to_back();
        test_random_wrap();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
